uart_rx_deframer: RTL



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tick_timeout.sv | 34 +++
 rtl/uart_rx_deframer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte-level framing logic.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN_ST  = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tick_timeout.sv
// Saturating tick counter; Expired flags the tick that reaches the limit (or any time after).
module uart_tick_timeout #(
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic Clear,
    input  logic Enable,
    input  logic Tick,
    output logic Expired
);
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;
    logic          w_last_tick;

    assign w_at_limit  = (r_cnt == CW'(TIMEOUT_TICKS));
    assign w_last_tick = Tick && (r_cnt == CW'(TIMEOUT_TICKS - 1));

    // Clear has priority so a byte coinciding with the terminal tick never times out.
    assign Expired = Enable && !Clear && (w_last_tick || w_at_limit);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_cnt <= '0;
        end else if (Clear) begin
            r_cnt <= '0;
        end else if (Enable && Tick && !w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// Parses SOF/LEN/payload/CHK frames from the UART receiver byte strobe.
// state   | meaning
// IDLE    | waiting for SOF, other bytes dropped
// LEN_ST  | SOF seen, next byte is the length
// PAYLOAD | streaming payload bytes out
// CHECK   | next byte is the XOR checksum
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int             DATA_BITS     = 8,
    parameter logic [7:0]     SOF_BYTE      = DEFAULT_SOF_BYTE,
    parameter int             MAX_LEN       = 16,
    parameter int             TIMEOUT_TICKS = 640
) (
    input  logic                       Clock,
    input  logic                       ResetN,
    input  logic                       Tick,
    input  logic                       RxReady,
    input  logic [DATA_BITS-1:0]       RxData,
    output logic                       PayloadValid,
    output logic [DATA_BITS-1:0]       PayloadData,
    output logic [$clog2(MAX_LEN)-1:0] PayloadIndex,
    output logic                       FrameDone,
    output logic                       FrameOk,
    output logic [1:0]                 ErrorCode,
    output logic                       Busy
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    state_t               r_state, w_state_nxt;
    logic [LW-1:0]        r_len, w_len_nxt;
    logic [IW-1:0]        r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_chk, w_chk_nxt;

    logic                 r_pv, w_pv_nxt;
    logic [DATA_BITS-1:0] r_pd, w_pd_nxt;
    logic [IW-1:0]        r_pi, w_pi_nxt;
    logic                 r_fd, w_fd_nxt;
    logic                 r_ok, w_ok_nxt;
    logic [1:0]           r_err, w_err_nxt;

    logic                 w_busy;
    logic                 w_expired;
    logic                 w_len_legal;
    logic                 w_last;

    assign w_busy      = (r_state != IDLE);
    assign w_len_legal = (RxData != '0) && (RxData <= DATA_BITS'(MAX_LEN));
    assign w_last      = ({1'b0, r_idx} == (r_len - LW'(1)));

    uart_tick_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .Clock  (Clock),
        .ResetN (ResetN),
        .Clear  (RxReady),
        .Enable (w_busy),
        .Tick   (Tick),
        .Expired(w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_chk_nxt   = r_chk;
        w_pv_nxt    = 1'b0;
        w_pd_nxt    = r_pd;
        w_pi_nxt    = r_pi;
        w_fd_nxt    = 1'b0;
        w_ok_nxt    = r_ok;
        w_err_nxt   = r_err;

        case (r_state)
            IDLE: begin
                if (RxReady && (RxData == DATA_BITS'(SOF_BYTE))) begin
                    w_state_nxt = LEN_ST;
                end
            end
            LEN_ST: begin
                if (RxReady) begin
                    if (w_len_legal) begin
                        w_len_nxt   = RxData[LW-1:0];
                        w_chk_nxt   = RxData;
                        w_idx_nxt   = '0;
                        w_state_nxt = PAYLOAD;
                    end else begin
                        w_fd_nxt    = 1'b1;
                        w_ok_nxt    = 1'b0;
                        w_err_nxt   = ERR_LEN;
                        w_state_nxt = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (RxReady) begin
                    w_pv_nxt  = 1'b1;
                    w_pd_nxt  = RxData;
                    w_pi_nxt  = r_idx;
                    w_chk_nxt = r_chk ^ RxData;
                    w_idx_nxt = r_idx + IW'(1);
                    if (w_last) begin
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (RxReady) begin
                    w_fd_nxt    = 1'b1;
                    w_ok_nxt    = (RxData == r_chk);
                    w_err_nxt   = (RxData == r_chk) ? ERR_NONE : ERR_CHK;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Expired is already gated off by RxReady and IDLE.
        if (w_expired) begin
            w_fd_nxt    = 1'b1;
            w_ok_nxt    = 1'b0;
            w_err_nxt   = ERR_TIMEOUT;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_chk   <= '0;
            r_pv    <= 1'b0;
            r_pd    <= '0;
            r_pi    <= '0;
            r_fd    <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_chk   <= w_chk_nxt;
            r_pv    <= w_pv_nxt;
            r_pd    <= w_pd_nxt;
            r_pi    <= w_pi_nxt;
            r_fd    <= w_fd_nxt;
            r_ok    <= w_ok_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign PayloadValid = r_pv;
    assign PayloadData  = r_pd;
    assign PayloadIndex = r_pi;
    assign FrameDone    = r_fd;
    assign FrameOk      = r_ok;
    assign ErrorCode    = r_err;
    assign Busy         = w_busy;

endmodule
